regfile_wb_ctrl: RTL and testbench

Write-back controller for the 16 x 32-bit RV32E register file. Arbitrates the file's single write port between the execute-stage result (ex) and the memory load-return path (ld). Tracks registers with loads in flight in a busy scoreboard, and reports read hazards to decode for the two source-register selects. Sits between the execute/LSU stages and the register file write port.

---
 rtl/regfile_wb_ctrl.sv | 112 +++++++++++
 tb/tb_regfile_wb_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_ctrl.sv
// Write-back arbiter for the RV32E register file write port: load returns win by default, ex gets priority after EX_MAX_WAIT blocked cycles; busy scoreboard tracks loads in flight.
// Optional macro REGFILE_WB_BYPASS_EN adds a forwarding path from the staged write and drops its hazard term.
module regfile_wb_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 4,
    parameter int EX_MAX_WAIT = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid_i,
    output logic                  ex_ready_o,
    input  logic [ADDR_W-1:0]     ex_rd_i,
    input  logic [DATA_W-1:0]     ex_data_i,
    input  logic                  ld_valid_i,
    output logic                  ld_ready_o,
    input  logic [ADDR_W-1:0]     ld_rd_i,
    input  logic [DATA_W-1:0]     ld_data_i,
    input  logic                  iss_valid_i,
    output logic                  iss_ready_o,
    input  logic [ADDR_W-1:0]     iss_rd_i,
    input  logic [ADDR_W-1:0]     rs1_sel_i,
    input  logic [ADDR_W-1:0]     rs2_sel_i,
    output logic                  rs1_hazard_o,
    output logic                  rs2_hazard_o,
`ifdef REGFILE_WB_BYPASS_EN
    output logic                  rs1_fwd_o,
    output logic                  rs2_fwd_o,
    output logic [DATA_W-1:0]     fwd_value_o,
`endif
    output logic [ADDR_W-1:0]     wr_sel_o,
    output logic [DATA_W-1:0]     wr_value_o,
    output logic [(1<<ADDR_W)-1:0] busy_vec_o
);

    localparam int          NREG = 1 << ADDR_W;
    localparam logic [3:0]  MAXW = 4'(EX_MAX_WAIT);

    logic [NREG-1:0]   busy_q, busy_d;
    logic [3:0]        starve_q, starve_d;
    logic [ADDR_W-1:0] wr_sel_q, wr_sel_d;
    logic [DATA_W-1:0] wr_value_q, wr_value_d;

    logic ex_elig, ex_prio, grant_ex, grant_ld;

    always_comb begin
        ex_elig     = ex_valid_i & ((ex_rd_i == '0) | ~busy_q[ex_rd_i]);
        ex_prio     = ex_elig & (starve_q == MAXW);
        grant_ld    = rst_n & ld_valid_i & ~ex_prio;
        grant_ex    = rst_n & ex_elig & ~grant_ld;
        iss_ready_o = rst_n & ((iss_rd_i == '0) | ~busy_q[iss_rd_i]);
        ex_ready_o  = grant_ex;
        ld_ready_o  = grant_ld;
    end

    always_comb begin
        busy_d     = busy_q;
        starve_d   = starve_q;
        wr_sel_d   = '0;
        wr_value_d = wr_value_q;

        // Clear before set so an issue and a return to the same register leave it busy.
        if (grant_ld)
            busy_d[ld_rd_i] = 1'b0;
        if (iss_valid_i && iss_ready_o && (iss_rd_i != '0))
            busy_d[iss_rd_i] = 1'b1;
        busy_d[0] = 1'b0;

        if (!ex_valid_i || grant_ex)
            starve_d = '0;
        else if (ex_elig && (starve_q != MAXW))
            starve_d = starve_q + 4'd1;

        if (grant_ex) begin
            wr_sel_d   = ex_rd_i;
            wr_value_d = ex_data_i;
        end else if (grant_ld) begin
            wr_sel_d   = ld_rd_i;
            wr_value_d = ld_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q     <= '0;
            starve_q   <= '0;
            wr_sel_q   <= '0;
            wr_value_q <= '0;
        end else begin
            busy_q     <= busy_d;
            starve_q   <= starve_d;
            wr_sel_q   <= wr_sel_d;
            wr_value_q <= wr_value_d;
        end
    end

    assign wr_sel_o   = wr_sel_q;
    assign wr_value_o = wr_value_q;
    assign busy_vec_o = busy_q;

`ifdef REGFILE_WB_BYPASS_EN
    assign rs1_fwd_o    = (rs1_sel_i != '0) & (wr_sel_q == rs1_sel_i);
    assign rs2_fwd_o    = (rs2_sel_i != '0) & (wr_sel_q == rs2_sel_i);
    assign fwd_value_o  = wr_value_q;
    assign rs1_hazard_o = (rs1_sel_i != '0) & busy_q[rs1_sel_i];
    assign rs2_hazard_o = (rs2_sel_i != '0) & busy_q[rs2_sel_i];
`else
    // The staged write has not reached the file yet, so its register is stale for one cycle.
    assign rs1_hazard_o = (rs1_sel_i != '0) & (busy_q[rs1_sel_i] | (wr_sel_q == rs1_sel_i));
    assign rs2_hazard_o = (rs2_sel_i != '0) & (busy_q[rs2_sel_i] | (wr_sel_q == rs2_sel_i));
`endif

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Bench for regfile_wb_ctrl: table of per-cycle vectors plus a write-port scoreboard, and hand-written reset sequences.
module tb_regfile_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_ready, ld_valid, ld_ready, iss_valid, iss_ready;
    logic [3:0]  ex_rd, ld_rd, iss_rd, rs1_sel, rs2_sel, wr_sel;
    logic [31:0] ex_data, ld_data, wr_value;
    logic        rs1_hazard, rs2_hazard;
    logic [15:0] busy_vec;
`ifdef REGFILE_WB_BYPASS_EN
    logic        rs1_fwd, rs2_fwd;
    logic [31:0] fwd_value;
`endif

    always #5 clk = ~clk;

    regfile_wb_ctrl #(.DATA_W(32), .ADDR_W(4), .EX_MAX_WAIT(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid_i(ex_valid), .ex_ready_o(ex_ready), .ex_rd_i(ex_rd), .ex_data_i(ex_data),
        .ld_valid_i(ld_valid), .ld_ready_o(ld_ready), .ld_rd_i(ld_rd), .ld_data_i(ld_data),
        .iss_valid_i(iss_valid), .iss_ready_o(iss_ready), .iss_rd_i(iss_rd),
        .rs1_sel_i(rs1_sel), .rs2_sel_i(rs2_sel),
        .rs1_hazard_o(rs1_hazard), .rs2_hazard_o(rs2_hazard),
`ifdef REGFILE_WB_BYPASS_EN
        .rs1_fwd_o(rs1_fwd), .rs2_fwd_o(rs2_fwd), .fwd_value_o(fwd_value),
`endif
        .wr_sel_o(wr_sel), .wr_value_o(wr_value), .busy_vec_o(busy_vec)
    );

    typedef struct {
        logic        ex_v;  logic [3:0] ex_rd;  logic [31:0] ex_d;
        logic        ld_v;  logic [3:0] ld_rd;  logic [31:0] ld_d;
        logic        iss_v; logic [3:0] iss_rd;
        logic [3:0]  rs1;   logic [3:0] rs2;
        logic        e_ex, e_ld, e_iss, e_h1, e_h2;
        logic [15:0] e_busy;
    } vec_t;

    typedef struct {
        logic [3:0]  sel;
        logic [31:0] val;
    } wr_t;

    vec_t vecs[$];
    wr_t  sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic exv, input logic [3:0] exr, input logic [31:0] exd,
                                input logic ldv, input logic [3:0] ldr, input logic [31:0] ldd,
                                input logic isv, input logic [3:0] isr,
                                input logic [3:0] r1, input logic [3:0] r2,
                                input logic eex, input logic eld, input logic eiss,
                                input logic eh1, input logic eh2, input logic [15:0] eb);
        vec_t v;
        v.ex_v = exv; v.ex_rd = exr; v.ex_d = exd;
        v.ld_v = ldv; v.ld_rd = ldr; v.ld_d = ldd;
        v.iss_v = isv; v.iss_rd = isr; v.rs1 = r1; v.rs2 = r2;
        v.e_ex = eex; v.e_ld = eld; v.e_iss = eiss; v.e_h1 = eh1; v.e_h2 = eh2; v.e_busy = eb;
        return v;
    endfunction

    task automatic pop_check(output wr_t e);
        e.sel = '0;
        e.val = '0;
        if (sb.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            chk("wr_sel", {28'd0, wr_sel}, {28'd0, e.sel});
            if (e.sel != 0) chk("wr_value", wr_value, e.val);
        end
    endtask

    task automatic apply(input vec_t v);
        wr_t e;
        wr_t n;
        @(negedge clk);
        ex_valid = v.ex_v;   ex_rd = v.ex_rd;   ex_data = v.ex_d;
        ld_valid = v.ld_v;   ld_rd = v.ld_rd;   ld_data = v.ld_d;
        iss_valid = v.iss_v; iss_rd = v.iss_rd;
        rs1_sel = v.rs1;     rs2_sel = v.rs2;
        #1;
        pop_check(e);
        chk("ex_ready", {31'd0, ex_ready}, {31'd0, v.e_ex});
        chk("ld_ready", {31'd0, ld_ready}, {31'd0, v.e_ld});
        chk("iss_ready", {31'd0, iss_ready}, {31'd0, v.e_iss});
        chk("busy_vec", {16'd0, busy_vec}, {16'd0, v.e_busy});
`ifdef REGFILE_WB_BYPASS_EN
        chk("rs1_hazard", {31'd0, rs1_hazard}, {31'd0, (v.rs1 != 0) && v.e_busy[v.rs1]});
        chk("rs2_hazard", {31'd0, rs2_hazard}, {31'd0, (v.rs2 != 0) && v.e_busy[v.rs2]});
        chk("rs1_fwd", {31'd0, rs1_fwd}, {31'd0, (v.rs1 != 0) && (e.sel == v.rs1)});
        chk("rs2_fwd", {31'd0, rs2_fwd}, {31'd0, (v.rs2 != 0) && (e.sel == v.rs2)});
        if ((v.rs1 != 0) && (e.sel == v.rs1)) chk("fwd_value", fwd_value, e.val);
`else
        chk("rs1_hazard", {31'd0, rs1_hazard}, {31'd0, v.e_h1});
        chk("rs2_hazard", {31'd0, rs2_hazard}, {31'd0, v.e_h2});
`endif
        n.sel = '0;
        n.val = '0;
        if (v.e_ex) begin
            n.sel = v.ex_rd; n.val = v.ex_d;
        end else if (v.e_ld) begin
            n.sel = v.ld_rd; n.val = v.ld_d;
        end
        sb.push_back(n);
    endtask

    initial begin
        wr_t e;
        rst_n = 1'b0;
        ex_valid = 1'b1; ex_rd = 4'd5; ex_data = 32'h1111_1111;
        ld_valid = 1'b1; ld_rd = 4'd6; ld_data = 32'h2222_2222;
        iss_valid = 1'b1; iss_rd = 4'd7;
        rs1_sel = 4'd5; rs2_sel = 4'd7;

        // Readies must be low while reset is held, whatever the inputs.
        @(negedge clk); #1;
        chk("rst_ex_ready", {31'd0, ex_ready}, 32'd0);
        chk("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
        chk("rst_iss_ready", {31'd0, iss_ready}, 32'd0);
        @(negedge clk);
        chk("rst_wr_sel", {28'd0, wr_sel}, 32'd0);
        chk("rst_wr_value", wr_value, 32'd0);
        chk("rst_busy", {16'd0, busy_vec}, 32'd0);
        chk("rst_rs1_hazard", {31'd0, rs1_hazard}, 32'd0);
        chk("rst_rs2_hazard", {31'd0, rs2_hazard}, 32'd0);
        ex_valid = 1'b0; ld_valid = 1'b0; iss_valid = 1'b0;
        rst_n = 1'b1;
        e.sel = '0; e.val = '0;
        sb.push_back(e);

        // ex write rd5, staged-write hazard for one cycle only
        vecs.push_back(mk(1,5,32'hDEADBEEF, 0,0,0, 0,0, 5,0, 1,0,1, 0,0, 16'h0000));
        vecs.push_back(mk(0,0,0,            0,0,0, 0,0, 5,0, 0,0,1, 1,0, 16'h0000));
        vecs.push_back(mk(0,0,0,            0,0,0, 0,0, 5,0, 0,0,1, 0,0, 16'h0000));
        // load pending on x7 blocks ex WAW until the load returns
        vecs.push_back(mk(0,0,0,     0,0,0,     1,7, 0,7, 0,0,1, 0,0, 16'h0000));
        vecs.push_back(mk(1,7,32'h77, 0,0,0,    0,0, 0,7, 0,0,1, 0,1, 16'h0080));
        vecs.push_back(mk(1,7,32'h77, 1,7,32'h12, 0,0, 0,7, 0,1,1, 0,1, 16'h0080));
        vecs.push_back(mk(1,7,32'h77, 0,0,0,    0,0, 0,7, 1,0,1, 0,1, 16'h0000));
        vecs.push_back(mk(0,0,0,     0,0,0,     0,0, 0,7, 0,0,1, 0,1, 16'h0000));
        vecs.push_back(mk(0,0,0,     0,0,0,     0,0, 0,7, 0,0,1, 0,0, 16'h0000));
        // ld and ex contend: 3 ld grants, then ex, then the count restarts
        vecs.push_back(mk(1,4,32'h44, 1,9,32'h101, 0,0, 4,9, 0,1,1, 0,0, 16'h0000));
        vecs.push_back(mk(1,4,32'h44, 1,9,32'h102, 0,0, 4,9, 0,1,1, 0,1, 16'h0000));
        vecs.push_back(mk(1,4,32'h44, 1,9,32'h103, 0,0, 4,9, 0,1,1, 0,1, 16'h0000));
        vecs.push_back(mk(1,4,32'h44, 1,9,32'h104, 0,0, 4,9, 1,0,1, 0,1, 16'h0000));
        vecs.push_back(mk(1,4,32'h48, 1,9,32'h105, 0,0, 4,9, 0,1,1, 1,0, 16'h0000));
        vecs.push_back(mk(1,4,32'h48, 1,9,32'h106, 0,0, 4,9, 0,1,1, 0,1, 16'h0000));
        vecs.push_back(mk(1,4,32'h48, 1,9,32'h107, 0,0, 4,9, 0,1,1, 0,1, 16'h0000));
        vecs.push_back(mk(1,4,32'h48, 1,9,32'h108, 0,0, 4,9, 1,0,1, 0,1, 16'h0000));
        vecs.push_back(mk(0,0,0,      0,0,0,       0,0, 4,9, 0,0,1, 1,0, 16'h0000));
        // same-cycle ld clear and iss set on x3: set wins
        vecs.push_back(mk(0,0,0, 1,3,32'h33, 1,3, 3,0, 0,1,1, 0,0, 16'h0000));
        vecs.push_back(mk(0,0,0, 0,0,0,      1,3, 3,0, 0,0,0, 1,0, 16'h0008));
        vecs.push_back(mk(0,0,0, 1,3,32'h34, 0,0, 3,0, 0,1,1, 1,0, 16'h0008));
        vecs.push_back(mk(0,0,0, 0,0,0,      0,0, 3,0, 0,0,1, 1,0, 16'h0000));
        // rd 0 writes are accepted and never produce a write or hazard
        vecs.push_back(mk(1,0,32'hFFFFFFFF, 0,0,0, 1,0, 0,0, 1,0,1, 0,0, 16'h0000));
        vecs.push_back(mk(0,0,0,            0,0,0, 0,0, 0,0, 0,0,1, 0,0, 16'h0000));
        // build busy = 0x00A0 plus a staged write before the mid-run reset
        vecs.push_back(mk(0,0,0,      0,0,0, 1,5, 5,7, 0,0,1, 0,0, 16'h0000));
        vecs.push_back(mk(0,0,0,      0,0,0, 1,7, 5,7, 0,0,1, 1,0, 16'h0020));
        vecs.push_back(mk(1,2,32'hAB, 0,0,0, 0,0, 5,7, 1,0,1, 1,1, 16'h00A0));

        foreach (vecs[i]) apply(vecs[i]);

        // mid-run reset with loads pending and a write staged
        @(negedge clk);
        rst_n = 1'b0;
        ex_valid = 1'b1; ex_rd = 4'd2; ex_data = 32'h55;
        ld_valid = 1'b1; ld_rd = 4'd5; ld_data = 32'h66;
        iss_valid = 1'b1; iss_rd = 4'd1;
        rs1_sel = 4'd2; rs2_sel = 4'd5;
        #1;
        pop_check(e);
`ifdef REGFILE_WB_BYPASS_EN
        chk("mid_rs1_fwd", {31'd0, rs1_fwd}, 32'd1);
        chk("mid_fwd_value", fwd_value, 32'hAB);
`endif
        chk("mid_busy_before", {16'd0, busy_vec}, 32'h00A0);
        chk("mid_ex_ready", {31'd0, ex_ready}, 32'd0);
        chk("mid_ld_ready", {31'd0, ld_ready}, 32'd0);
        chk("mid_iss_ready", {31'd0, iss_ready}, 32'd0);
        @(negedge clk); #1;
        chk("mid_busy_after", {16'd0, busy_vec}, 32'd0);
        chk("mid_wr_sel", {28'd0, wr_sel}, 32'd0);
        chk("mid_wr_value", wr_value, 32'd0);
        chk("mid_rs1_hazard", {31'd0, rs1_hazard}, 32'd0);
        chk("mid_rs2_hazard", {31'd0, rs2_hazard}, 32'd0);
        chk("mid_ex_ready_hold", {31'd0, ex_ready}, 32'd0);

        rst_n = 1'b1;
        ld_valid = 1'b0; iss_valid = 1'b0;
        #1;
        chk("post_rst_ex_ready", {31'd0, ex_ready}, 32'd1);
        @(negedge clk);
        ex_valid = 1'b0;
        #1;
        chk("post_rst_wr_sel", {28'd0, wr_sel}, 32'd2);
        chk("post_rst_wr_value", wr_value, 32'h55);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
